// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite slave to APB3/APB4 master bridge with a configurable slot count,
// slot-decode field, optional PREADY timeout and a two-cycle AHB ERROR response.
// Unmapped slots, PSLVERR and timeouts all return ERROR.
module ahb_apb_bridge_param #(
  parameter int unsigned NUM_SLAVES = 16,
  parameter int unsigned SEL_LSB    = 24,
  parameter int unsigned TIMEOUT    = 0,
  parameter bit          APB4       = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [3:0]  slot_q;
  logic [31:0] paddr_q;
  logic        pwrite_q;
  logic [3:0]  pstrb_q;
  logic [2:0]  pprot_q;
  logic [31:0] pwdata_q;
  logic [15:0] tcnt;

  logic [3:0]  slot_in;
  logic        mapped_in;
  logic        req;
  logic        done_ok;
  logic        timed_out;
  logic        accept;
  logic [3:0]  strb_in;
  logic [2:0]  prot_in;
  logic [NUM_SLAVES-1:0] sel_dec;
  state_t      accept_target;

  assign slot_in   = HADDR[SEL_LSB+3:SEL_LSB];
  assign mapped_in = (32'(slot_in) < NUM_SLAVES);
  assign req       = HSEL & HREADYIN & HTRANS[1];
  assign done_ok   = (state == ACCESS) & PREADY & ~PSLVERR;
  assign timed_out = (TIMEOUT != 0) && (state == ACCESS) && !PREADY && (tcnt == TO_LAST);
  assign accept    = req & ((state == IDLE) | (state == ERR2) | done_ok);
  assign accept_target = mapped_in ? SETUP : ERR1;

  // Byte strobes and protection bits derived from the address-phase attributes.
  always_comb begin
    strb_in = 4'h0;
    if (HWRITE) begin
      if (!APB4) begin
        strb_in = 4'hF;
      end else begin
        case (HSIZE)
          3'd0:    strb_in = 4'b0001 << HADDR[1:0];
          3'd1:    strb_in = HADDR[1] ? 4'b1100 : 4'b0011;
          default: strb_in = 4'hF;
        endcase
      end
    end
    prot_in = APB4 ? {~HPROT[0], 1'b1, HPROT[1]} : 3'b000;
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and AHB response.
  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = accept_target;
      end
      SETUP: begin
        HREADYOUT = 1'b0;
        state_nx  = ACCESS;
      end
      ACCESS: begin
        if (PREADY && !PSLVERR) begin
          state_nx = accept ? accept_target : IDLE;
        end else if (PREADY || timed_out) begin
          HREADYOUT = 1'b0;
          HRESP     = 1'b1;
          state_nx  = ERR2;
        end else begin
          HREADYOUT = 1'b0;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = ERR2;
      end
      ERR2: begin
        HRESP    = 1'b1;
        state_nx = accept ? accept_target : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latch address-phase attributes on accept; capture write data at end of SETUP.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      slot_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      pwdata_q <= '0;
    end else begin
      if (accept) begin
        slot_q   <= slot_in;
        paddr_q  <= HADDR;
        pwrite_q <= HWRITE;
        pstrb_q  <= strb_in;
        pprot_q  <= prot_in;
      end
      if (state == SETUP) pwdata_q <= HWDATA;
    end
  end

  // Count ACCESS cycles spent waiting on PREADY; cleared outside the wait.
  always_ff @(posedge HCLK) begin
    if (HRESET)                          tcnt <= '0;
    else if (state == ACCESS && !PREADY) tcnt <= tcnt + 16'd1;
    else                                 tcnt <= '0;
  end

  // One-hot slot decode and APB outputs.
  always_comb begin
    sel_dec = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) sel_dec[i] = (32'(slot_q) == i);
    PSEL    = ((state == SETUP) || (state == ACCESS)) ? sel_dec : '0;
    PENABLE = (state == ACCESS);
    PWDATA  = (state == SETUP) ? HWDATA : pwdata_q;
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PSTRB  = pstrb_q;
  assign PPROT  = pprot_q;
  assign HRDATA = PRDATA;

endmodule
